// File: rtl/systolic_sequencer.sv
// Job sequencer for an N x N output-stationary systolic array: clears the PEs,
// feeds K skewed operand beats, drains the wavefront and holds results until acked.
module systolic_sequencer #(
  parameter int N  = 16,
  parameter int KW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
  output logic            busy_o,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic [N*8-1:0]  a_col_i,
  input  logic [N*8-1:0]  b_row_i,
  output logic            arr_clear_o,
  output logic            arr_process_o,
  output logic [N*8-1:0]  arr_a_o,
  output logic [N*8-1:0]  arr_b_o,
  output logic            done_o,
  input  logic            result_ack_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int DW = $clog2(2 * N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 2);

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] kReg_q, kReg_d;
  logic [KW-1:0] beatCnt_q, beatCnt_d;
  logic [DW-1:0] drainCnt_q, drainCnt_d;
  logic          beatAccept;

  assign beatAccept = a_valid_i && (state_q == FEED);

  always_comb begin
    state_d    = state_q;
    kReg_d     = kReg_q;
    beatCnt_d  = beatCnt_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          kReg_d  = k_len_i;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        beatCnt_d  = '0;
        drainCnt_d = DRAIN_LAST;
        state_d    = (kReg_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (beatAccept) begin
          beatCnt_d = beatCnt_q + KW'(1);
          if (beatCnt_q == kReg_q - KW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Down-counter spans the full 2N-1 cycle diagonal wavefront.
        if (drainCnt_q == '0) begin
          state_d = DONE;
        end else begin
          drainCnt_d = drainCnt_q - DW'(1);
        end
      end
      DONE: begin
        if (result_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      kReg_q     <= '0;
      beatCnt_q  <= '0;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kReg_q     <= kReg_d;
      beatCnt_q  <= beatCnt_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign a_ready_o     = (state_q == FEED);
  assign arr_clear_o   = (state_q == CLEAR);
  assign arr_process_o = (state_q == FEED) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);

  // Lane i holds i+1 stages so operands enter the array diagonally aligned.
  for (genvar i = 0; i < N; i++) begin : gLane
    logic [7:0] aPipe_q [0:i];
    logic [7:0] bPipe_q [0:i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s <= i; s++) begin
          aPipe_q[s] <= '0;
          bPipe_q[s] <= '0;
        end
      end else if (state_q == CLEAR) begin
        for (int s = 0; s <= i; s++) begin
          aPipe_q[s] <= '0;
          bPipe_q[s] <= '0;
        end
      end else begin
        aPipe_q[0] <= beatAccept ? a_col_i[i*8 +: 8] : 8'h00;
        bPipe_q[0] <= beatAccept ? b_row_i[i*8 +: 8] : 8'h00;
        for (int s = 1; s <= i; s++) begin
          aPipe_q[s] <= aPipe_q[s-1];
          bPipe_q[s] <= bPipe_q[s-1];
        end
      end
    end

    assign arr_a_o[i*8 +: 8] = aPipe_q[i];
    assign arr_b_o[i*8 +: 8] = bPipe_q[i];
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench: drives jobs through systolic_sequencer into a behavioural
// 4x4 output-stationary PE array and checks timing, skew and products.
module tb_systolic_sequencer;

  localparam int N    = 4;
  localparam int KW   = 16;
  localparam int MAXC = 64;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   kLen = '0;
  logic            busy;
  logic            aValid = 1'b0;
  logic            aReady;
  logic [N*8-1:0]  aCol = '0;
  logic [N*8-1:0]  bRow = '0;
  logic            arrClear;
  logic            arrProcess;
  logic [N*8-1:0]  arrA;
  logic [N*8-1:0]  arrB;
  logic            done;
  logic            resultAck = 1'b0;

  always #5 clk = ~clk;

  systolic_sequencer #(.N(N), .KW(KW)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .start_i       (start),
    .k_len_i       (kLen),
    .busy_o        (busy),
    .a_valid_i     (aValid),
    .a_ready_o     (aReady),
    .a_col_i       (aCol),
    .b_row_i       (bRow),
    .arr_clear_o   (arrClear),
    .arr_process_o (arrProcess),
    .arr_a_o       (arrA),
    .arr_b_o       (arrB),
    .done_o        (done),
    .result_ack_i  (resultAck)
  );

  // Behavioural PE array: a flows right, b flows down, C accumulates in place.
  logic [31:0] accM [N][N];
  logic [7:0]  aP [N][N];
  logic [7:0]  bP [N][N];

  function automatic logic [7:0] aInOf(int i, int j);
    return (j == 0) ? arrA[i*8 +: 8] : aP[i][j-1];
  endfunction

  function automatic logic [7:0] bInOf(int i, int j);
    return (i == 0) ? arrB[j*8 +: 8] : bP[i-1][j];
  endfunction

  always @(posedge clk or negedge rstN) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!rstN || arrClear) begin
          accM[i][j] <= '0;
          aP[i][j]   <= '0;
          bP[i][j]   <= '0;
        end else begin
          aP[i][j] <= aInOf(i, j);
          bP[i][j] <= bInOf(i, j);
          if (arrProcess) accM[i][j] <= accM[i][j] + 32'(aInOf(i, j)) * 32'(bInOf(i, j));
        end
      end
    end
  end

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;
  int cycle = 0;
  int doneCycle, clearCount, clearCycle, readyCount, processCount, bubbleCount;
  logic [7:0] matA [N][8];
  logic [7:0] matB [8][N];
  logic [7:0] traceA [N][MAXC];
  logic [7:0] traceB [N][MAXC];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Runs one job from the start pulse (cycle 0) until done is observed.
  task automatic applyStimulus(input int k, input bit bubbles, input bit midStart, input bit earlyAck);
    int beat;
    bit phase;
    bit accepted;
    beat = 0;
    phase = 1'b0;
    clearCount = 0; clearCycle = -1; readyCount = 0; processCount = 0; bubbleCount = 0;
    doneCycle = -1;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < MAXC; c++) begin
        traceA[i][c] = '0;
        traceB[i][c] = '0;
      end
    cycle = 0;
    start = 1'b1;
    kLen = KW'(k);
    resultAck = earlyAck;
    stepCycle();
    start = 1'b0;
    for (int g = 0; g < 200 && doneCycle < 0; g++) begin
      if (cycle < MAXC)
        for (int i = 0; i < N; i++) begin
          traceA[i][cycle] = arrA[i*8 +: 8];
          traceB[i][cycle] = arrB[i*8 +: 8];
        end
      if (arrClear) begin clearCount++; clearCycle = cycle; end
      if (aReady) readyCount++;
      if (arrProcess) processCount++;
      if (done) begin
        doneCycle = cycle;
        resultAck = 1'b0;
      end else begin
        if (aReady && bubbles && phase) begin
          aValid = 1'b0;
          aCol = {N{8'hAA}};
          bRow = {N{8'h55}};
          bubbleCount++;
        end else begin
          aValid = 1'b1;
          for (int i = 0; i < N; i++) begin
            aCol[i*8 +: 8] = (beat < k) ? matA[i][beat] : 8'hEE;
            bRow[i*8 +: 8] = (beat < k) ? matB[beat][i] : 8'hEE;
          end
        end
        if (aReady) phase = !phase;
        if (midStart && aReady && beat == 1) begin
          start = 1'b1;
          kLen = KW'(2);
        end else begin
          start = 1'b0;
        end
        accepted = aReady && aValid;
        stepCycle();
        if (accepted) beat++;
      end
    end
    start = 1'b0;
    aValid = 1'b0;
  endtask

  task automatic ackJob(input bit withStart);
    stepCycle();
    checkOutput("done_hold", 32'(done), 32'd1);
    resultAck = 1'b1;
    start = withStart;
    stepCycle();
    resultAck = 1'b0;
    start = 1'b0;
    checkOutput("done_after_ack", 32'(done), 32'd0);
    checkOutput("busy_after_ack", 32'(busy), 32'd0);
    if (withStart) begin
      stepCycle();
      checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
    end
  endtask

  task automatic setMatrices(input int kind);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) begin
        case (kind)
          0: begin matA[i][k] = (i == k) ? 8'd1 : 8'd0; matB[k][i] = 8'(4 * k + i + 1); end
          1: begin matA[i][k] = 8'd1; matB[k][i] = 8'd1; end
          2: begin matA[i][k] = 8'(i + 1); matB[k][i] = 8'(16 + i); end
          3: begin matA[i][k] = 8'd2; matB[k][i] = 8'(i + 1); end
          default: begin matA[i][k] = 8'(i + 1); matB[k][i] = 8'd1; end
        endcase
      end
  endtask

  initial begin
    int stray;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(aReady), 32'd0);
    checkOutput("rst_clear", 32'(arrClear), 32'd0);
    checkOutput("rst_process", 32'(arrProcess), 32'd0);
    checkOutput("rst_arr_a", arrA, 32'd0);
    checkOutput("rst_arr_b", arrB, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    #13 rstN = 1'b1;
    stepCycle();

    $display("[TB] job 1: identity A, K=4");
    setMatrices(0);
    applyStimulus(4, 1'b0, 1'b0, 1'b0);
    checkOutput("j1_done_cycle", doneCycle, 32'd13);
    checkOutput("j1_clear_count", clearCount, 32'd1);
    checkOutput("j1_clear_cycle", clearCycle, 32'd1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        checkOutput($sformatf("j1_c%0d%0d", i, j), accM[i][j], 32'(4 * i + j + 1));
    ackJob(1'b0);

    $display("[TB] job 2: ones, alternating bubbles");
    setMatrices(1);
    applyStimulus(4, 1'b1, 1'b0, 1'b0);
    checkOutput("j2_bubbles", bubbleCount, 32'd3);
    checkOutput("j2_done_cycle", doneCycle, 32'd16);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        checkOutput($sformatf("j2_c%0d%0d", i, j), accM[i][j], 32'd4);
    ackJob(1'b0);

    $display("[TB] job 3: single-beat skew");
    setMatrices(2);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("j3_done_cycle", doneCycle, 32'd10);
    stray = 0;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("j3_arr_a%0d", i), 32'(traceA[i][3 + i]), 32'(i + 1));
      checkOutput($sformatf("j3_arr_b%0d", i), 32'(traceB[i][3 + i]), 32'(16 + i));
      for (int c = 1; c <= doneCycle && c < MAXC; c++)
        if (c != 3 + i && (traceA[i][c] != 0 || traceB[i][c] != 0)) stray++;
    end
    checkOutput("j3_stray_operands", stray, 32'd0);
    checkOutput("j3_c33", accM[3][3], 32'd76);
    ackJob(1'b0);

    $display("[TB] job 4: k_len=0 with early ack");
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("j4_done_cycle", doneCycle, 32'd9);
    checkOutput("j4_ready_count", readyCount, 32'd0);
    checkOutput("j4_drain_cycles", processCount, 32'd7);
    checkOutput("j4_c00", accM[0][0], 32'd0);
    checkOutput("j4_c33", accM[3][3], 32'd0);
    ackJob(1'b0);

    $display("[TB] job 5/6: mid-feed start then back-to-back");
    setMatrices(3);
    applyStimulus(3, 1'b0, 1'b1, 1'b0);
    checkOutput("j5_done_cycle", doneCycle, 32'd12);
    for (int j = 0; j < N; j++)
      checkOutput($sformatf("j5_c2%0d", j), accM[2][j], 32'(6 * (j + 1)));
    ackJob(1'b1);
    setMatrices(4);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    checkOutput("j6_done_cycle", doneCycle, 32'd11);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("j6_c%0d1", i), accM[i][1], 32'(2 * (i + 1)));
    ackJob(1'b0);

    $display("[TB] reset during drain");
    setMatrices(1);
    cycle = 0;
    start = 1'b1;
    kLen = KW'(2);
    aValid = 1'b1;
    aCol = {N{8'd1}};
    bRow = {N{8'd1}};
    stepCycle();
    start = 1'b0;
    for (int g = 0; g < 5; g++) stepCycle();
    checkOutput("rd_in_drain", {30'd0, aReady, arrProcess}, 32'd1);
    checkOutput("rd_lane3_live", 32'(arrA[31:24]), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rd_busy", 32'(busy), 32'd0);
    checkOutput("rd_process", 32'(arrProcess), 32'd0);
    checkOutput("rd_arr_a", arrA, 32'd0);
    checkOutput("rd_arr_b", arrB, 32'd0);
    checkOutput("rd_done", 32'(done), 32'd0);
    aValid = 1'b0;
    stepCycle();
    #3 rstN = 1'b1;
    stepCycle();
    checkOutput("rd_idle_after_release", 32'(busy), 32'd0);
    applyStimulus(4, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_fresh_done_cycle", doneCycle, 32'd13);
    checkOutput("rd_fresh_c00", accM[0][0], 32'd4);
    checkOutput("rd_fresh_c33", accM[3][3], 32'd4);
    ackJob(1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
